// File: rtl/mem_responder.sv
// Single-port memory responder: clears itself after reset, serves reads with a
// fixed pipeline latency and pulses err for every request it rejects.
module mem_responder #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          busy,
  output logic          err
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] data_out_q, data_out_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [DW-1:0]       pipe_data_q [READ_LAT];
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;

  logic req, in_range, legal_wr, legal_rd;

  always_comb begin
    req      = read | write;
    in_range = {1'b0, addr} < DEPTH_W;
    legal_wr = (state_q == ST_IDLE) && write && !read && in_range;
    legal_rd = (state_q == ST_IDLE) && read && !write && in_range;
  end

  // The clear sweep and user writes share the one write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        err_d     = req;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        mem_we = legal_wr;
        err_d  = req && !(legal_wr || legal_rd);
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_first
        assign pipe_vld_d[gi] = legal_rd;
      end else begin : g_next
        assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    rd_valid_d = pipe_vld_q[READ_LAT-1];
    data_out_d = rd_valid_d ? pipe_data_q[READ_LAT-1] : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
      pipe_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Storage and read-data pipeline carry no reset; only the valid bits flush.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (legal_rd) begin
      pipe_data_q[0] <= mem[addr];
    end
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (default, DEPTH=24,
// READ_LAT=3); stimulus pushes expected responses, a monitor pops and compares.
module tb_mem_responder;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst_n_a [3];
  logic       read_a  [3];
  logic       write_a [3];
  logic [4:0] addr_a  [3];
  logic [7:0] din_a   [3];
  logic [7:0] dout_a  [3];
  logic       rdv_a   [3];
  logic       busy_a  [3];
  logic       err_a   [3];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t rd_q  [$];
  exp_t err_q [$];
  exp_t mon_e;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mem_responder #(
        .AW(5), .DW(8),
        .DEPTH(gi == 1 ? 24 : 32),
        .READ_LAT(gi == 2 ? 3 : 1)
      ) u_dut (
        .clk(clk), .rst_n(rst_n_a[gi]), .read(read_a[gi]), .write(write_a[gi]),
        .addr(addr_a[gi]), .data_in(din_a[gi]), .data_out(dout_a[gi]),
        .rd_valid(rdv_a[gi]), .busy(busy_a[gi]), .err(err_a[gi])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every rd_valid / err pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdv_a[i]) begin
        chk("rd_expected", int'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          mon_e = rd_q.pop_front();
          chk("rd_inst", i, mon_e.inst);
          chk("rd_data", int'(dout_a[i]), int'(mon_e.data));
          chk("rd_cycle", cyc, mon_e.due);
          $display("rd   inst=%0d data=0x%02h cycle=%0d", i, dout_a[i], cyc);
        end
      end
      if (err_a[i]) begin
        chk("err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          mon_e = err_q.pop_front();
          chk("err_inst", i, mon_e.inst);
          chk("err_cycle", cyc, mon_e.due);
          $display("err  inst=%0d cycle=%0d", i, cyc);
        end
      end
    end
  end

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    read_a[i]  = r;
    write_a[i] = w;
    addr_a[i]  = a;
    din_a[i]   = d;
  endtask

  task automatic do_write(input int i, input logic [4:0] a, input logic [7:0] d);
    drive(i, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_read(input int i, input logic [4:0] a, input logic [7:0] exp, input int lat);
    drive(i, 1'b1, 1'b0, a, 8'h00);
    rd_q.push_back('{inst: i, data: exp, due: cyc + 1 + lat});
  endtask

  task automatic do_bad(input int i, input logic r, input logic w,
                        input logic [4:0] a, input logic [7:0] d);
    drive(i, r, w, a, d);
    err_q.push_back('{inst: i, data: 8'h00, due: cyc + 1});
  endtask

  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) drive(i, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (busy_a[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", int'(busy_a[i]), 0);
  endtask

  initial begin
    int busy_cnt;
    for (int i = 0; i < 3; i++) begin
      rst_n_a[i] = 1'b0; read_a[i] = 1'b0; write_a[i] = 1'b0;
      addr_a[i] = 5'd0; din_a[i] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_a[0]), 1);
    chk("rst_dout", int'(dout_a[0]), 0);
    chk("rst_rdv", int'(rdv_a[0]), 0);
    chk("rst_err", int'(err_a[0]), 0);
    for (int i = 0; i < 3; i++) rst_n_a[i] = 1'b1;

    // Count busy cycles of instance 0; poke instance 1 while it clears.
    busy_cnt = 0;
    while (busy_a[0] && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 3) begin
        read_a[1] = 1'b1; addr_a[1] = 5'd3;
        err_q.push_back('{inst: 1, data: 8'h00, due: cyc + 1});
      end
      if (busy_cnt == 4) read_a[1] = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, 32);
    $display("busy inst=0 cycles=%0d", busy_cnt);

    // Cleared contents read back as zero.
    for (int a = 0; a < 32; a++) do_read(0, 5'(a), 8'h00, 1);
    idle(0, 3);

    // Data equals address, then back-to-back reads.
    for (int a = 0; a < 32; a++) do_write(0, 5'(a), 8'(a));
    for (int a = 0; a < 32; a++) do_read(0, 5'(a), 8'(a), 1);
    idle(0, 3);

    // Collision leaves addr 5 intact.
    do_bad(0, 1'b1, 1'b1, 5'd5, 8'hAA);
    idle(0, 1);
    do_read(0, 5'd5, 8'h05, 1);
    idle(0, 3);

    // DEPTH=24: out-of-range accesses are rejected and do not alias.
    wait_ready(1);
    do_bad(1, 1'b0, 1'b1, 5'd30, 8'h77);
    do_bad(1, 1'b0, 1'b1, 5'd24, 8'h66);
    do_write(1, 5'd23, 8'h5A);
    do_read(1, 5'd23, 8'h5A, 1);
    do_read(1, 5'd6, 8'h00, 1);
    do_read(1, 5'd14, 8'h00, 1);
    do_read(1, 5'd0, 8'h00, 1);
    do_bad(1, 1'b1, 1'b0, 5'd24, 8'h00);
    idle(1, 3);

    // READ_LAT=3: latency, then a reset that kills an in-flight read.
    wait_ready(2);
    do_write(2, 5'd7, 8'h3C);
    do_read(2, 5'd7, 8'h3C, 3);
    idle(2, 6);
    chk("lat3_hold", int'(dout_a[2]), 'h3C);
    drive(2, 1'b1, 1'b0, 5'd7, 8'h00);
    drive(2, 1'b0, 1'b0, 5'd0, 8'h00);
    rst_n_a[2] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy_a[2]), 1);
    chk("midrst_dout", int'(dout_a[2]), 0);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_rdv", int'(rdv_a[2]), 0);
      @(negedge clk);
    end
    rst_n_a[2] = 1'b1;
    @(negedge clk);
    wait_ready(2);
    do_read(2, 5'd7, 8'h00, 3);
    idle(2, 5);

    // Read immediately after write returns the new data.
    do_write(0, 5'd12, 8'hC3);
    do_read(0, 5'd12, 8'hC3, 1);
    idle(0, 5);
    chk("dout_hold", int'(dout_a[0]), 'hC3);

    idle(0, 5);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
